abox_inv_stage: RTL and testbench
=================================

# abox_inv_stage

Pipelined, handshaked inverse of the masked PRINCE affine box: it undoes the nibble-wise affine layer applied around the threshold-implemented S-box. The block sits on the decryption / inverse-S-box datapath of the 4-share TI PRINCE core. It processes all shares of a 64-bit state in parallel, with the affine constant applied to share 0 only. A 2-entry skid buffer provides the glitch-stopping register and full-throughput valid/ready flow control.

## Interface
Parameters:
- NIBBLES, 16: nibbles per share (state width = 4*NIBBLES).
- SHARES, 4: number of Boolean shares; must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  stage can accept a beat.
- in_data  input  SHARES*4*NIBBLES  shares concatenated, share 0 in LSBs; nibble n of share s at bits [s*4*NIBBLES + 4n +: 4].
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts.
- out_data  output  SHARES*4*NIBBLES  transformed shares, same layout.

## Operation
- Per nibble z (bits z0..z3), linear part L: x0 = z0^z1^z3, x1 = z0, x2 = z3, x3 = z2.
- Share 0 output = L(z) XOR 4'b1011 (bits x0, x1, x3 inverted). Shares 1..SHARES-1 output = L(z) only. This gives XOR of output shares = inverse affine of XOR of input shares.
- Transform is combinational on in_data. Only the transformed value is registered; raw in_data is never stored.
- No cross-share logic: each output share bit depends on exactly one input share. Verified by structure, not by simulation.
- Skid buffer: entries main (drives out_data) and skid. Occupancy count 0..2.
  - Accept when in_valid && in_ready. Pop when out_valid && out_ready.
  - count=0: accept → main, count 1.
  - count=1, accept and pop: main ← new beat, count stays 1.
  - count=1, accept, no pop: skid ← new beat, count 2.
  - count=1, pop only: count 0.
  - count=2, pop: main ← skid, count 1. No accept is possible at count 2.
- in_ready = (count < 2) && !rst. out_valid = (count ≥ 1).
- Beat order is preserved. No beat is dropped or duplicated.
- Reset:
  - count ← 0; main and skid ← 0.
  - out_valid = 0, out_data = 0, in_ready = 0 while rst is high, in_ready = 1 on the first cycle after.
  - Reset mid-operation discards both entries. A beat presented during the rst cycle is not accepted.

## Timing
- Latency 1 cycle: a beat accepted at edge k appears on out_data/out_valid after edge k (if the buffer was empty).
- Throughput 1 beat/cycle while out_ready stays high.
- in_ready is a function of registered count only, with no combinational path from out_ready. out_data comes straight from the main register.
- After out_ready drops for one cycle with continuous input, in_ready falls after 2 cycles at most. Recovery is 1 beat per cycle once out_ready returns.

## Structure
- Package prince_ti_pkg:
  - NIBBLE_W = 4.
  - ABOX_INV_CONST = 4'b1011.
  - SHARES default.
  - Function abox_inv_lin(nibble).
- Sub-module abox_inv_nibble (parameter NEG: 1 for share 0, 0 otherwise): purely combinational, instantiated SHARES*NIBBLES times via generate.
- The top level holds only the skid buffer control and registers.

## Test plan
- Unmasked vectors (shares 1..3 = 0, single nibble shown):
  - share0 = 0x5 → out share0 0x0.
  - share0 = 0xA → 0xF.
  - Roundtrip: each of the 16 values through abox_with_neg then this block returns the original.
- Masked: share0 = 0x9, share1 = 0x3, others 0 → out share0 0xD, share1 0x2, XOR 0xF (same as unmasked 0xA).
- Backpressure: stream beats 1,2,3,4 with out_ready low for 3 cycles after beat 1 → in_ready drops after beat 2 is taken, and the output sequence is exactly 1,2,3,4 with no loss.
- Simultaneous accept and pop at count=1 for 10 cycles → count stays 1, one output per cycle, in_ready constantly 1.
- Reset with count=2 → next cycle out_valid=0, out_data=0, in_ready=0; a beat offered during rst never appears; in_ready=1 the cycle after rst falls.
- Random 64-bit, 4-share traffic with random valid/ready over 10k beats against a scoreboard model → the unmasked output equals the inverse affine of the unmasked input for every beat.

Source files
------------

// File: rtl/prince_ti_pkg.sv
// Shared constants and helpers for the threshold-implemented PRINCE datapath.
package prince_ti_pkg;

    localparam int unsigned NIBBLE_W       = 4;
    localparam int unsigned DEFAULT_SHARES = 4;
    localparam logic [NIBBLE_W-1:0] ABOX_INV_CONST = 4'b1011;

    // Linear part of the inverse affine box: x0=z0^z1^z3, x1=z0, x2=z3, x3=z2.
    function automatic logic [NIBBLE_W-1:0] abox_inv_lin(input logic [NIBBLE_W-1:0] z);
        return {z[2], z[3], z[0], z[0] ^ z[1] ^ z[3]};
    endfunction

endpackage

// File: rtl/abox_inv_nibble.sv
// Inverse affine box on one nibble of one share; the constant is applied only when NEG is set.
module abox_inv_nibble
    import prince_ti_pkg::*;
#(
    parameter bit NEG = 1'b0
) (
    input  logic [NIBBLE_W-1:0] z,
    output logic [NIBBLE_W-1:0] x
);

    localparam logic [NIBBLE_W-1:0] Mask = NEG ? ABOX_INV_CONST : '0;

    assign x = abox_inv_lin(z) ^ Mask;

endmodule

// File: rtl/abox_inv_stage.sv
// Share-parallel inverse affine layer followed by a 2-entry skid buffer that acts as the
// glitch-stopping register and gives full-throughput valid/ready flow control.
module abox_inv_stage
    import prince_ti_pkg::*;
#(
    parameter int unsigned NIBBLES = 16,
    parameter int unsigned SHARES  = DEFAULT_SHARES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SHARES*NIBBLE_W*NIBBLES-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SHARES*NIBBLE_W*NIBBLES-1:0] out_data
);

    localparam int unsigned ShareW = NIBBLE_W * NIBBLES;
    localparam int unsigned DataW  = SHARES * ShareW;

    logic [DataW-1:0] xf_data;
    logic [DataW-1:0] main_q, main_d;
    logic [DataW-1:0] skid_q, skid_d;
    logic [1:0]       count_q, count_d;
    logic             accept, pop;

    // Each output nibble sees exactly one input nibble of the same share.
    for (genvar s = 0; s < SHARES; s++) begin : g_share
        for (genvar n = 0; n < NIBBLES; n++) begin : g_nib
            abox_inv_nibble #(
                .NEG (s == 0)
            ) u_nib (
                .z (in_data[s*ShareW + n*NIBBLE_W +: NIBBLE_W]),
                .x (xf_data[s*ShareW + n*NIBBLE_W +: NIBBLE_W])
            );
        end
    end

    assign in_ready  = (count_q < 2'd2) && !rst;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = main_q;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_comb begin
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = count_q;
        unique case (count_q)
            2'd0: begin
                if (accept) begin
                    main_d  = xf_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (accept && pop) begin
                    main_d = xf_data;
                end else if (accept) begin
                    skid_d  = xf_data;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    main_d  = skid_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q  <= '0;
            skid_q  <= '0;
            count_q <= 2'd0;
        end else begin
            main_q  <= main_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_abox_inv_stage.sv
// Directed and random checks of abox_inv_stage: transform values, flow control and reset.
module tb_abox_inv_stage;

    localparam int W  = 64;
    localparam int DW = 4 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    abox_inv_stage #(
        .NIBBLES (16),
        .SHARES  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Hand-derived full inverse affine (linear part plus 4'b1011).
    function automatic logic [3:0] inv_tab(input logic [3:0] z);
        case (z)
            4'h0: return 4'hB;  4'h1: return 4'h8;  4'h2: return 4'hA;  4'h3: return 4'h9;
            4'h4: return 4'h3;  4'h5: return 4'h0;  4'h6: return 4'h2;  4'h7: return 4'h1;
            4'h8: return 4'hE;  4'h9: return 4'hD;  4'hA: return 4'hF;  4'hB: return 4'hC;
            4'hC: return 4'h6;  4'hD: return 4'h5;  4'hE: return 4'h7;  default: return 4'h4;
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_beat(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        logic [3:0]    v;
        r = '0;
        for (int s = 0; s < 4; s++) begin
            for (int n = 0; n < 16; n++) begin
                v = inv_tab(d[s*W + 4*n +: 4]);
                if (s != 0) v = v ^ 4'hB;
                r[s*W + 4*n +: 4] = v;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] xor_shares(input logic [DW-1:0] d);
        return d[0 +: W] ^ d[W +: W] ^ d[2*W +: W] ^ d[3*W +: W];
    endfunction

    function automatic logic [W-1:0] inv_affine64(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_tab(v[4*n +: 4]);
        return r;
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (out_data !== '0) begin
            failures++; $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [DW-1:0] vin [5];
        logic [DW-1:0] vexp[5];
        vin[0]  = {64'h0, 64'h0, 64'h0, 64'h5555_5555_5555_5555};
        vexp[0] = {64'h0, 64'h0, 64'h0, 64'h0};
        vin[1]  = {64'h0, 64'h0, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA};
        vexp[1] = {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        vin[2]  = {64'h0, 64'h0, 64'h3333_3333_3333_3333, 64'h9999_9999_9999_9999};
        vexp[2] = {64'h0, 64'h0, 64'h2222_2222_2222_2222, 64'hDDDD_DDDD_DDDD_DDDD};
        // Share 0 holds the forward affine of nibble index n in nibble n.
        vin[3]  = {64'h0, 64'h0, 64'h0, 64'hA89B_0231_ECDF_4675};
        vexp[3] = {64'h0, 64'h0, 64'h0, 64'hFEDC_BA98_7654_3210};
        vin[4]  = {64'h1111_1111_1111_1111, 64'h8888_8888_8888_8888,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vexp[4] = {64'h3333_3333_3333_3333, 64'h5555_5555_5555_5555,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'hBBBB_BBBB_BBBB_BBBB};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = vin[i];
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL vec%0d_valid: got %b expected 1", i, out_valid);
            end
            checks++;
            if (out_data !== vexp[i]) begin
                failures++;
                $display("FAIL vec%0d_data: got %h expected %h", i, out_data, vexp[i]);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] beat[4];
        int sent = 0;
        int recv = 0;
        for (int k = 0; k < 4; k++) beat[k] = {4{64'(k + 1) * 64'h0123_4567_89AB_CDEF}};
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 1 && c <= 3);
            in_valid  = (sent < 4);
            in_data   = (sent < 4) ? beat[sent] : '0;
            #1;
            if (c == 2) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++; $display("FAIL bp_in_ready_drop: got %b expected 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (recv >= 4) begin
                    failures++; $display("FAIL bp_extra_beat: got %h expected none", out_data);
                end else if (out_data !== exp_beat(beat[recv])) begin
                    failures++;
                    $display("FAIL bp_order%0d: got %h expected %h", recv, out_data,
                             exp_beat(beat[recv]));
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        checks++;
        if (recv != 4) begin
            failures++; $display("FAIL bp_count: got %0d expected 4", recv);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d[11];
        for (int i = 0; i < 11; i++) d[i] = {8{32'h1000_0001 * 32'(i + 3)}};
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d[0];
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_data   = d[i+1];
            out_ready = 1'b1;
            #1;
            checks++;
            if (!(in_ready === 1'b1 && out_valid === 1'b1 && out_data === exp_beat(d[i]))) begin
                failures++;
                $display("FAIL b2b%0d: got rdy=%b vld=%b %h expected rdy=1 vld=1 %h", i,
                         in_ready, out_valid, out_data, exp_beat(d[i]));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_beat(d[10])) begin
            failures++;
            $display("FAIL b2b_last: got vld=%b %h expected vld=1 %h", out_valid, out_data,
                     exp_beat(d[10]));
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_drained: got %b expected 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {4{64'h1234_5678_9ABC_DEF0}};
        @(negedge clk);
        in_data = {4{64'h0FED_CBA9_8765_4321}};
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL rm_full_in_ready: got %b expected 0", in_ready);
        end
        rst     = 1'b1;
        in_data = {4{64'hDEAD_BEEF_CAFE_F00D}};
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rm_during_rst: got vld=%b rdy=%b %h expected vld=0 rdy=0 0",
                     out_valid, in_ready, out_data);
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL rm_release_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rm_beat_leaked: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] e;
        int sent = 0;
        int recv = 0;
        int n_beats = 10000;
        for (int c = 0; c < 60000 && recv < n_beats; c++) begin
            @(negedge clk);
            in_valid = (sent < n_beats) && ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 8; k++) in_data[32*k +: 32] = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rnd_unexpected: got %h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (xor_shares(out_data) !== e) begin
                        failures++;
                        $display("FAIL rnd_beat%0d: got %h expected %h", recv,
                                 xor_shares(out_data), e);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(inv_affine64(xor_shares(in_data)));
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (recv != n_beats) begin
            failures++; $display("FAIL rnd_count: got %0d expected %0d", recv, n_beats);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
